ecap5_wb_arbiter: RTL and testbench

// - N-master to 1-slave arbiter for the pipelined Wishbone bus; sits between the core's

---
 rtl/ecap5_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_ecap5_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecap5_wb_arbiter.sv
// Round-robin N-master to 1-slave arbiter for the pipelined Wishbone bus.
// One master owns the slave port for a whole cyc; acks return only to that owner.
module ecap5_wb_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
    output logic [DATA_WIDTH-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_stall_o,
    output logic [ADDR_WIDTH-1:0]                 wb_adr_o,
    output logic [DATA_WIDTH-1:0]                 wb_dat_o,
    output logic [DATA_WIDTH/8-1:0]               wb_sel_o,
    output logic                                  wb_we_o,
    output logic                                  wb_cyc_o,
    output logic                                  wb_stb_o,
    input  logic [DATA_WIDTH-1:0]                 wb_dat_i,
    input  logic                                  wb_ack_i,
    input  logic                                  wb_stall_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IW        = $clog2(NUM_MASTERS);
    localparam int CW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);

    // Handshake: a strobe is accepted on a cycle with stb=1 and stall=0; an ack
    // completes the oldest accepted strobe. Dropping cyc aborts anything outstanding.

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   rr, rr_n;
    logic [CW-1:0]   count, count_n;

    logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
    logic [SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];

    logic          owned;
    logic          active;
    logic          release_bus;
    logic          full;
    logic          ack_fwd;
    logic          stb_accept;
    logic [IW-1:0] owner_succ;
    logic [IW-1:0] search_base;
    logic          grant_found;
    logic [IW-1:0] grant_idx;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            adr_arr[i] = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            dat_arr[i] = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            sel_arr[i] = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        end
    end

    assign owned       = (state == ST_OWNED);
    assign active      = owned & m_cyc_i[owner];
    assign release_bus = owned & ~m_cyc_i[owner];
    assign full        = (count == MAX_CNT);
    assign ack_fwd     = active & wb_ack_i & (count != '0);
    assign stb_accept  = wb_stb_o & ~wb_stall_i;
    assign owner_succ  = (owner == LAST_IDX) ? '0 : owner + IW'(1);
    // On release the search starts just past the old owner, so the hand-over edge
    // already uses the advanced pointer.
    assign search_base = release_bus ? owner_succ : rr;

    // First requester at or above the base, otherwise the lowest one (wrap-around).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!grant_found && m_cyc_i[i] && (IW'(i) >= search_base)) begin
                grant_found = 1'b1;
                grant_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!grant_found && m_cyc_i[i]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            owner <= '0;
            rr    <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            rr    <= rr_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr;
        count_n = count;
        if (!owned || release_bus) begin
            count_n = '0;
            if (release_bus) begin
                rr_n = owner_succ;
            end
            if (grant_found) begin
                state_n = ST_OWNED;
                owner_n = grant_idx;
            end else begin
                state_n = ST_IDLE;
            end
        end else begin
            case ({stb_accept, ack_fwd})
                2'b10:   count_n = count + CW'(1);
                2'b01:   count_n = count - CW'(1);
                default: count_n = count;
            endcase
        end
    end

    always_comb begin
        wb_cyc_o  = active;
        wb_stb_o  = active & m_stb_i[owner] & ~full;
        wb_we_o   = active & m_we_i[owner];
        wb_adr_o  = active ? adr_arr[owner] : '0;
        wb_dat_o  = active ? dat_arr[owner] : '0;
        wb_sel_o  = active ? sel_arr[owner] : '0;
        m_dat_o   = wb_dat_i;
        m_ack_o   = '0;
        m_stall_o = '1;
        if (active) begin
            m_stall_o[owner] = wb_stall_i | full;
            m_ack_o[owner]   = ack_fwd;
        end
    end

endmodule

// File: tb/tb_ecap5_wb_arbiter.sv
// Bench for ecap5_wb_arbiter: directed scenarios with literal expectations, then
// randomized masters and slave, all checked every cycle against an ownership model.
module tb_ecap5_wb_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXO = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_stall_o;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [SW-1:0]     wb_sel_o;
    logic              wb_we_o, wb_cyc_o, wb_stb_o;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_i, wb_stall_i;

    ecap5_wb_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_stall_o(m_stall_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cyc"}, wb_cyc_o, 0);
        check({tag, "_stb"}, wb_stb_o, 0);
        check({tag, "_ack"}, m_ack_o, 0);
        check({tag, "_stall"}, m_stall_o, {N{1'b1}});
        check({tag, "_adr"}, wb_adr_o, 0);
        check({tag, "_dat"}, wb_dat_o, 0);
        check({tag, "_sel"}, wb_sel_o, 0);
        check({tag, "_we"}, wb_we_o, 0);
    endtask

    // ---------------- behavioural model + compare process ----------------
    // Owner is an integer index, outstanding is a plain integer count.
    bit       mv = 0;
    int       mo = 0;
    int       mrr = 0;
    int       mcnt = 0;
    bit       e_act, e_full, e_stb;
    logic [N-1:0] e_stall, e_ack;

    always @(negedge clk_i) begin
        if (rst_i) begin
            check_idle("rst");
            mv = 0; mo = 0; mrr = 0; mcnt = 0;
        end else begin
            e_act   = mv && m_cyc_i[mo];
            e_full  = (mcnt >= MAXO);
            e_stb   = e_act && m_stb_i[mo] && !e_full;
            e_stall = '1;
            e_ack   = '0;
            if (e_act) begin
                e_stall[mo] = wb_stall_i || e_full;
                e_ack[mo]   = wb_ack_i && (mcnt > 0);
            end
            check("mdl_cyc", wb_cyc_o, e_act);
            check("mdl_stb", wb_stb_o, e_stb);
            check("mdl_stall", m_stall_o, e_stall);
            check("mdl_ack", m_ack_o, e_ack);
            check("mdl_adr", wb_adr_o, e_act ? m_adr_i[mo*AW +: AW] : '0);
            check("mdl_wdat", wb_dat_o, e_act ? m_dat_i[mo*DW +: DW] : '0);
            check("mdl_sel", wb_sel_o, e_act ? m_sel_i[mo*SW +: SW] : '0);
            check("mdl_we", wb_we_o, e_act && m_we_i[mo]);
            if (e_ack != 0) check("mdl_rdat", m_dat_o, wb_dat_i);
            // advance to the state seen after the coming rising edge
            if (mv && !m_cyc_i[mo]) begin
                mrr = (mo + 1) % N;
                mv = 0;
                mcnt = 0;
            end else if (e_act) begin
                mcnt = mcnt + ((e_stb && !wb_stall_i) ? 1 : 0) - ((e_ack != 0) ? 1 : 0);
            end
            if (!mv) begin
                for (int k = 0; k < N; k++) begin
                    if (!mv && m_cyc_i[(mrr + k) % N]) begin
                        mv = 1;
                        mo = (mrr + k) % N;
                        mcnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_m(input int i, input logic cyc, input logic stb, input logic [AW-1:0] adr);
        m_cyc_i[i] = cyc;
        m_stb_i[i] = stb;
        m_we_i[i]  = 1'b0;
        m_adr_i[i*AW +: AW] = adr;
        m_dat_i[i*DW +: DW] = $urandom;
        m_sel_i[i*SW +: SW] = '1;
    endtask

    task automatic set_s(input logic ack, input logic stall, input logic [DW-1:0] dat);
        wb_ack_i = ack;
        wb_stall_i = stall;
        wb_dat_i = dat;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_check();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int i = 0; i < N; i++) set_m(i, 0, 0, 0);
        set_s(0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];

    // ---------------- random stimulus state ----------------
    int left [N];
    int pend [N];
    bit in_cyc [N];
    bit acc [N];
    int due_q[$];
    int cyc_no = 0;
    int last_due = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        at_check();
        check_idle("reset");

        // contention and round-robin
        next_cycle(); set_m(0, 1, 0, 0); set_m(1, 1, 0, 0);
        at_check(); check("arb_req_stall", m_stall_o, 2'b11); check("arb_req_cyc", wb_cyc_o, 0);
        next_cycle();
        at_check(); check("arb_m0_grant", m_stall_o, 2'b10); check("arb_m0_cyc", wb_cyc_o, 1);
        next_cycle(); set_m(0, 0, 0, 0);
        at_check(); check("arb_rel_cyc", wb_cyc_o, 0);
        next_cycle();
        at_check(); check("arb_m1_grant", m_stall_o, 2'b01); check("arb_m1_cyc", wb_cyc_o, 1);
        next_cycle(); set_m(1, 0, 0, 0);
        at_check(); check("arb_m1_rel", wb_cyc_o, 0);
        next_cycle(); set_m(0, 1, 0, 0); set_m(1, 1, 0, 0);
        at_check(); check("arb_req2_stall", m_stall_o, 2'b11);
        next_cycle();
        at_check(); check("arb_rr_wrap", m_stall_o, 2'b10);
        next_cycle(); set_m(0, 0, 0, 0); set_m(1, 0, 0, 0);

        // single master reads, outstanding limit, slave stall, isolation, release
        do_reset();
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEF0);
        exp_q.push_back(32'hDEADBEF1);
        next_cycle(); set_m(0, 1, 1, 32'h100);
        at_check(); check("rd_req_stall", m_stall_o[0], 1); check("rd_req_stb", wb_stb_o, 0);
        next_cycle();
        at_check(); check("rd0_stb", wb_stb_o, 1); check("rd0_adr", wb_adr_o, 32'h100);
        check("rd0_stall", m_stall_o[0], 0);
        next_cycle(); set_m(0, 1, 1, 32'h104);
        at_check(); check("rd1_stb", wb_stb_o, 1); check("rd1_adr", wb_adr_o, 32'h104);
        next_cycle(); set_m(0, 1, 1, 32'h108); set_s(1, 0, 32'hDEADBEEF);
        at_check(); check("lim_stall", m_stall_o[0], 1); check("lim_stb", wb_stb_o, 0);
        check("rd_ack0", m_ack_o, 2'b01); check("rd_dat0", m_dat_o, exp_q.pop_front());
        next_cycle(); set_s(1, 0, 32'hDEADBEF0);
        at_check(); check("lim_accept", wb_stb_o, 1); check("lim_unstall", m_stall_o[0], 0);
        check("rd2_adr", wb_adr_o, 32'h108);
        check("rd_ack1", m_ack_o, 2'b01); check("rd_dat1", m_dat_o, exp_q.pop_front());
        next_cycle(); set_m(0, 1, 0, 32'h108); set_s(0, 0, 0);
        at_check(); check("rd_gap_ack", m_ack_o, 0);
        next_cycle(); set_s(1, 0, 32'hDEADBEF1);
        at_check(); check("rd_ack2", m_ack_o, 2'b01); check("rd_dat2", m_dat_o, exp_q.pop_front());
        next_cycle(); set_s(1, 0, 32'h55);
        at_check(); check("spurious_ack", m_ack_o, 0);
        next_cycle(); set_m(0, 1, 1, 32'h200); set_m(1, 1, 0, 0); set_s(0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            at_check();
            check("sstall_stall", m_stall_o, 2'b11);
            check("sstall_stb", wb_stb_o, 1);
            check("sstall_adr", wb_adr_o, 32'h200);
        end
        next_cycle(); set_s(0, 0, 0);
        at_check(); check("sstall_release", m_stall_o, 2'b10);
        next_cycle(); set_m(0, 1, 0, 32'h200); set_s(1, 0, 32'hCAFE0001);
        at_check(); check("iso_ack", m_ack_o, 2'b01); check("iso_stall", m_stall_o[1], 1);
        next_cycle(); set_m(0, 1, 1, 32'h300); set_s(0, 0, 0);
        at_check(); check("pre_rel_stb", wb_stb_o, 1);
        next_cycle(); set_m(0, 0, 0, 0); set_s(1, 0, 32'h1);
        at_check(); check("rel_ack_drop", m_ack_o, 0); check("rel_cyc", wb_cyc_o, 0);
        next_cycle(); set_s(1, 0, 32'h2);
        at_check(); check("regrant_m1", m_stall_o, 2'b01); check("regrant_cyc", wb_cyc_o, 1);
        check("late_ack_drop", m_ack_o, 0);
        next_cycle(); set_m(1, 1, 1, 32'h400); set_s(0, 0, 0);
        at_check(); check("m1_stb0", wb_stb_o, 1); check("m1_adr0", wb_adr_o, 32'h400);
        next_cycle(); set_m(1, 1, 1, 32'h404);
        at_check(); check("m1_stb1", wb_stb_o, 1);
        next_cycle(); set_m(1, 1, 1, 32'h408);
        #1;
        check("pre_rst_full", m_stall_o, 2'b11); check("pre_rst_cyc", wb_cyc_o, 1);
        #1 rst_i = 1'b1;
        #1 check_idle("async_rst");
        at_check();
        next_cycle(); rst_i = 1'b0; set_m(1, 1, 0, 0);
        at_check(); check("post_rst_req", m_stall_o, 2'b11);
        next_cycle();
        at_check(); check("post_rst_m1", m_stall_o, 2'b01);
        next_cycle(); set_m(1, 0, 0, 0);

        // randomized masters and slave
        for (int i = 0; i < N; i++) begin
            left[i] = 0; pend[i] = 0; in_cyc[i] = 0; acc[i] = 0;
        end
        repeat (3000) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                acc[i] = m_cyc_i[i] && m_stb_i[i] && !m_stall_o[i];
                if (acc[i]) begin
                    left[i]--;
                    pend[i]++;
                end
                if (m_ack_o[i] && pend[i] > 0) pend[i]--;
            end
            if (!wb_cyc_o) begin
                due_q.delete();
            end else if (wb_stb_o && !wb_stall_i) begin
                int d;
                d = cyc_no + $urandom_range(1, 4);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                due_q.push_back(d);
            end
            next_cycle();
            cyc_no++;
            wb_stall_i = ($urandom_range(0, 3) == 0);
            if (due_q.size() > 0 && due_q[0] <= cyc_no) begin
                wb_ack_i = 1'b1;
                void'(due_q.pop_front());
            end else begin
                wb_ack_i = ($urandom_range(0, 31) == 0);
            end
            wb_dat_i = $urandom;
            for (int i = 0; i < N; i++) begin
                if (!in_cyc[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_cyc[i] = 1;
                        left[i] = $urandom_range(1, 6);
                        pend[i] = 0;
                    end
                end else if ((left[i] <= 0 && pend[i] == 0) || $urandom_range(0, 63) == 0) begin
                    in_cyc[i] = 0;
                end
                m_cyc_i[i] = in_cyc[i];
                if (!in_cyc[i] || left[i] <= 0) begin
                    m_stb_i[i] = 1'b0;
                end else if (!(m_stb_i[i] && !acc[i])) begin
                    m_stb_i[i] = ($urandom_range(0, 3) != 0);
                    m_we_i[i]  = $urandom_range(0, 1);
                    m_adr_i[i*AW +: AW] = $urandom;
                    m_dat_i[i*DW +: DW] = $urandom;
                    m_sel_i[i*SW +: SW] = SW'($urandom);
                end
            end
        end
        next_cycle();

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
